// File: rtl/rx_substate_checker_if.sv
// Signal bundle between the main LTSSM / lane comparators (master) and the RX substate checker (slave).
interface rx_substate_checker_if #(
    parameter int MAXLANES  = 16,
    parameter int LANECNT_W = 5
);
    logic [3:0]           substate;
    logic [LANECNT_W-1:0] numberOfDetectedLanes;
    logic [MAXLANES-1:0]  countersComparators;
    logic                 rxElectricalIdle;
    logic                 timeOut;
    logic                 finish;
    logic [3:0]           exitTo;
    logic [MAXLANES-1:0]  resetOsCheckers;
    logic [2:0]           timeToWait;
    logic                 startTimer;
    logic                 enableTimer;
    logic [4:0]           comparatorsCount;
    logic [LANECNT_W-1:0] linkWidth;

    modport master (
        output substate, numberOfDetectedLanes, countersComparators, rxElectricalIdle, timeOut,
        input  finish, exitTo, resetOsCheckers, timeToWait, startTimer, enableTimer,
               comparatorsCount, linkWidth
    );

    modport slave (
        input  substate, numberOfDetectedLanes, countersComparators, rxElectricalIdle, timeOut,
        output finish, exitTo, resetOsCheckers, timeToWait, startTimer, enableTimer,
               comparatorsCount, linkWidth
    );
endinterface

// File: rtl/rx_substate_checker.sv
// RX LTSSM substate checker: arms the shared timer per substate, watches lane comparators,
// electrical idle and timeout, and reports one finish pulse. Optional macro: PARTIAL_WIDTH_EN.
module rx_substate_lane #(
    parameter int LANECNT_W = 5,
    parameter int IDX       = 0
) (
    input  logic [LANECNT_W-1:0] i_n,
    input  logic                 i_n_ok,
    input  logic                 i_cmp,
    output logic                 o_active,
    output logic                 o_ok
);
    localparam logic [31:0] IDXU = 32'(IDX);

    assign o_active = i_n_ok && (32'(i_n) > IDXU);
    // Lanes outside the detected width never block a full match.
    assign o_ok     = !o_active || i_cmp;
endmodule

module rx_substate_checker #(
    parameter int MAXLANES  = 16,
    parameter int LANECNT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    rx_substate_checker_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

    state_t               r_state, w_nstate;
    logic [3:0]           r_sub, w_sub_d;
    logic [3:0]           r_last, w_last_d;
    logic                 r_finish, w_finish_d;
    logic [3:0]           r_exit, w_exit_d;
    logic [MAXLANES-1:0]  r_roc, w_roc_d;
    logic [2:0]           r_ttw, w_ttw_d;
    logic                 r_start, w_start_d;
    logic                 r_en, w_en_d;
    logic [4:0]           r_cc, w_cc_d;
    logic [LANECNT_W-1:0] r_lw, w_lw_d;

    logic                 w_n_ok;
    logic [MAXLANES-1:0]  w_active;
    logic [MAXLANES-1:0]  w_ok;
    logic                 w_all;
    logic [LANECNT_W-1:0] w_n;

    assign w_n    = bus.numberOfDetectedLanes;
    assign w_n_ok = (w_n != '0) && (32'(w_n) <= 32'(MAXLANES));

    for (genvar g = 0; g < MAXLANES; g++) begin : g_lane
        rx_substate_lane #(.LANECNT_W(LANECNT_W), .IDX(g)) u_lane (
            .i_n      (w_n),
            .i_n_ok   (w_n_ok),
            .i_cmp    (bus.countersComparators[g]),
            .o_active (w_active[g]),
            .o_ok     (w_ok[g])
        );
    end

    assign w_all = w_n_ok && (&w_ok);

`ifdef PARTIAL_WIDTH_EN
    logic [MAXLANES:0]    w_pre;
    logic [32:0]          w_pre_pad;
    logic [LANECNT_W-1:0] w_pw;
    logic [MAXLANES-1:0]  w_pw_mask;

    // w_pre[i] = lanes 0..i-1 all match
    always_comb begin
        w_pre[0] = 1'b1;
        for (int i = 0; i < MAXLANES; i++) w_pre[i+1] = w_pre[i] & bus.countersComparators[i];
    end
    assign w_pre_pad = 33'(w_pre);

    always_comb begin
        w_pw = '0;
        for (int k = 0; k < 6; k++)
            if (w_n_ok && ((32'(1) << k) <= 32'(w_n)) && w_pre_pad[6'(32'(1) << k)])
                w_pw = LANECNT_W'(32'(1) << k);
    end
    assign w_pw_mask = MAXLANES'((64'(1) << w_pw) - 64'(1));
`endif

    // {timeToWait, comparatorsCount} per substate
    function automatic logic [7:0] f_table(input logic [3:0] s);
        case (s)
            4'd0:                 f_table = {3'd1, 5'd0};
            4'd1:                 f_table = {3'd0, 5'd0};
            4'd2:                 f_table = {3'd2, 5'd8};
            4'd3:                 f_table = {3'd3, 5'd8};
            4'd4, 4'd5, 4'd7:     f_table = {3'd2, 5'd2};
            4'd6:                 f_table = {3'd4, 5'd2};
            4'd8:                 f_table = {3'd2, 5'd8};
            4'd9:                 f_table = {3'd4, 5'd8};
            default:              f_table = 8'd0;
        endcase
    endfunction

    always_comb begin
        w_nstate   = r_state;
        w_sub_d    = r_sub;
        w_last_d   = r_last;
        w_finish_d = 1'b0;
        w_start_d  = 1'b0;
        w_exit_d   = r_exit;
        w_roc_d    = r_roc;
        w_ttw_d    = r_ttw;
        w_en_d     = r_en;
        w_cc_d     = r_cc;
        w_lw_d     = r_lw;
        case (r_state)
            S_IDLE: begin
                w_en_d  = 1'b0;
                w_roc_d = '0;
                if (bus.substate != r_last && bus.substate <= 4'd9) begin
                    w_nstate           = S_ARM;
                    w_sub_d            = bus.substate;
                    {w_ttw_d, w_cc_d}  = f_table(bus.substate);
                    w_start_d          = 1'b1;
                    w_en_d             = 1'b1;
                    w_roc_d            = w_active;
                end
            end
            S_ARM: begin
                w_nstate = S_COUNT;
                w_en_d   = 1'b1;
            end
            S_COUNT: begin
                w_en_d = 1'b1;
                if ((r_sub == 4'd0 && (bus.rxElectricalIdle || bus.timeOut)) ||
                    (r_sub == 4'd1 && bus.timeOut) ||
                    (r_sub > 4'd1 && !bus.timeOut && w_all) ||
                    (r_sub <= 4'd1 && w_all)) begin
                    w_nstate   = S_DONE;
                    w_finish_d = 1'b1;
                    w_en_d     = 1'b0;
                    w_roc_d    = '0;
                    w_last_d   = r_sub;
                    w_exit_d   = r_sub + 4'd1;
                    w_lw_d     = w_n;
                end else if (bus.timeOut) begin
                    w_nstate   = S_DONE;
                    w_finish_d = 1'b1;
                    w_en_d     = 1'b0;
                    w_roc_d    = '0;
                    w_last_d   = r_sub;
                    w_exit_d   = 4'd0;
                    w_lw_d     = '0;
`ifdef PARTIAL_WIDTH_EN
                    // Fall back to the widest power-of-two prefix of matching lanes.
                    if ((r_sub == 4'd4 || r_sub == 4'd5) && w_pw != '0) begin
                        w_exit_d = r_sub + 4'd1;
                        w_lw_d   = w_pw;
                        w_roc_d  = w_pw_mask;
                    end
`endif
                end else if (bus.substate != r_sub) begin
                    w_nstate = S_IDLE;
                    w_en_d   = 1'b0;
                    w_roc_d  = '0;
                end
            end
            S_DONE: begin
                w_nstate = S_IDLE;
                w_en_d   = 1'b0;
                w_roc_d  = '0;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sub    <= 4'd0;
            r_last   <= 4'hF;
            r_finish <= 1'b0;
            r_exit   <= 4'd0;
            r_roc    <= '0;
            r_ttw    <= 3'd0;
            r_start  <= 1'b0;
            r_en     <= 1'b0;
            r_cc     <= 5'd0;
            r_lw     <= '0;
        end else begin
            r_state  <= w_nstate;
            r_sub    <= w_sub_d;
            r_last   <= w_last_d;
            r_finish <= w_finish_d;
            r_exit   <= w_exit_d;
            r_roc    <= w_roc_d;
            r_ttw    <= w_ttw_d;
            r_start  <= w_start_d;
            r_en     <= w_en_d;
            r_cc     <= w_cc_d;
            r_lw     <= w_lw_d;
        end
    end

    assign bus.finish           = r_finish;
    assign bus.exitTo           = r_exit;
    assign bus.resetOsCheckers  = r_roc;
    assign bus.timeToWait       = r_ttw;
    assign bus.startTimer       = r_start;
    assign bus.enableTimer      = r_en;
    assign bus.comparatorsCount = r_cc;
    assign bus.linkWidth        = r_lw;
endmodule

// File: doc/rx_substate_checker.md
Name: rx_substate_checker

Overview:
Parametrised successor to the master RX LTSSM checker. It takes a substate request from the main LTSSM and arms the shared timer with that substate's timeout code. It then watches the per-lane ordered-set comparators, electrical idle and timeout, and reports one finish pulse with the exit substate. Compared with the previous generation it adds:
- any lane count from 1 to MAXLANES, not only powers of two;
- per-lane checker release;
- abort on a substate change mid-check;
- optional partial-width fallback.

Parameters:
MAXLANES, 16, number of lane comparator/checker slots (1..32)
LANECNT_W, 5, width of numberOfDetectedLanes and linkWidth; must satisfy 2^LANECNT_W > MAXLANES

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
substate  in  4  substate request from main LTSSM (0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration, 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle)
numberOfDetectedLanes  in  LANECNT_W  lanes detected in Detect
countersComparators  in  MAXLANES  per-lane "required OS count reached"
rxElectricalIdle  in  1  receiver electrical idle
timeOut  in  1  timer expired
finish  out  1  one-cycle completion pulse
exitTo  out  4  next substate; valid while finish=1
resetOsCheckers  out  MAXLANES  active-low per-lane OS checker reset
timeToWait  out  3  timer code: 0=0ms, 1=12ms, 2=24ms, 3=48ms, 4=2ms
startTimer  out  1  one-cycle timer load
enableTimer  out  1  timer run enable
comparatorsCount  out  5  required consecutive OS count for checkers
linkWidth  out  LANECNT_W  negotiated width reported at finish

Behaviour:
- All outputs are registered.
- Reset values: finish=0, exitTo=0, resetOsCheckers=0, timeToWait=0, startTimer=0, enableTimer=0, comparatorsCount=0, linkWidth=0.
- Internal state: FSM=IDLE, lastState=4'hF.
- activeMask = (1<<N)-1 for N = numberOfDetectedLanes in 1..MAXLANES; otherwise activeMask = 0.
- Per-substate table (timeToWait / comparatorsCount):
  - 0: 1 / 0
  - 1: 0 / 0
  - 2: 2 / 8
  - 3: 3 / 8
  - 4, 5, 7: 2 / 2
  - 6: 4 / 2
  - 8: 2 / 8
  - 9: 4 / 8
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE:
  - A request is accepted when substate != lastState and substate <= 9; next state is ARM.
  - Substates 10-15 are ignored; the block stays in IDLE.
  - Outputs: resetOsCheckers=0, enableTimer=0.
- ARM (exactly 1 cycle):
  - Latch the substate.
  - Drive table values; startTimer=1, enableTimer=1.
  - resetOsCheckers = activeMask; inactive lanes stay held in reset.
  - Next state: COUNT.
- COUNT: startTimer=0, enableTimer=1. Evaluated in priority order each cycle:
  1. Latched substate 0: rxElectricalIdle=1 or timeOut=1 -> DONE, success.
  2. Latched substate 1: timeOut=1 -> DONE, success.
  3. Other substates: timeOut=1 -> DONE, fail. Timeout wins over a simultaneous match.
  4. (countersComparators & activeMask) == activeMask and activeMask != 0 -> DONE, success.
  5. The substate input differs from the latched substate -> abort: return to IDLE, no finish, lastState unchanged, checkers reset. The new request is accepted on the following IDLE cycle.
- DONE (1 cycle):
  - finish=1, enableTimer=0, resetOsCheckers=0, lastState=latched substate, next state IDLE.
  - On success: exitTo = substate+1 (cfgIdle exits to 10 = L0).
  - On fail: exitTo = 0 (detectQuiet).
  - linkWidth = N on success, 0 on fail.
- Latency:
  - Request to startTimer: 1 cycle.
  - Qualifying COUNT cycle to finish: 1 cycle.
- Repeating the same substate after a finish is not a new request; the block stays in IDLE.
- Asserting reset at any point returns all outputs to reset values asynchronously.

Optional Feature:
PARTIAL_WIDTH_EN
- Defined: applies to latched substates 4 and 5 when timeOut=1 in COUNT. Let W = the largest power of two <= N such that lanes 0..W-1 all match. If W >= 1, the result is success with exitTo = substate+1 and linkWidth = W; resetOsCheckers for lanes >= W are driven to 0 in DONE.
- Not defined: timeout in substates 4 and 5 fails as in all other substates; linkWidth is only ever N or 0.

Test Plan:
- Reset asserted mid-COUNT -> next edge finish=0, resetOsCheckers=0, enableTimer=0; after release, substate=0 is accepted again because lastState=4'hF.
- substate 0->2, N=4, countersComparators=16'h000F two cycles after ARM -> startTimer pulse with timeToWait=2 and comparatorsCount=8; finish=1 with exitTo=3, linkWidth=4.
- N=3, countersComparators=16'h0007 in substate 6 -> resetOsCheckers=16'h0007 during COUNT; finish with exitTo=7, linkWidth=3.
- Substate 3, match 16'h00FF and timeOut in the same cycle, N=8 -> finish with exitTo=0, linkWidth=0.
- Substate changes 2->8 during COUNT -> no finish; ARM for 8 one cycle later with timeToWait=2 and comparatorsCount=8.
- PARTIAL_WIDTH_EN, substate 4, N=8, lanes 0-3 match, timeOut -> exitTo=5, linkWidth=4; without the macro -> exitTo=0, linkWidth=0.
